// File: rtl/mcd_pkg.sv
// Shared definitions for the microstep control decoder.
//   LO_W       default width of the low pass-through field of a micro-op
//   R_IN_OFS   offset of the r_in bit above the low field
//   R_OUT_OFS  offset of the r_out bit above the low field
//   state_e    sequencer states
//   calc_out_w width of the expanded control word
package mcd_pkg;

   localparam int LO_W      = 10;
   localparam int R_IN_OFS  = 0;
   localparam int R_OUT_OFS = 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // The two register-enable bits are replaced by two NREG-wide one-hot fields.
   function automatic int calc_out_w(input int cw_w, input int nreg);
      return cw_w - 2 + 2 * nreg;
   endfunction

endpackage

// File: rtl/onehot_reg_decoder.sv
// Register-select to one-hot enable decoder.
//   sel    in   SEL_W  register select
//   en     in   1      enable request
//   onehot out  NREG   one-hot enable, all zero when en=0 or sel out of range
//   bad    out  1      en set with sel >= NREG
module onehot_reg_decoder #(
   parameter int  NREG  = 4,
   localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [NREG-1:0]  onehot,
   output logic             bad
);

   // One extra bit so the range compare stays meaningful when NREG is a power of two.
   logic [SEL_W:0] sel_x;

   assign sel_x = {1'b0, sel};
   assign bad   = en && (sel_x >= (SEL_W + 1)'(NREG));

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NREG; i++) begin
         onehot[i] = en && (sel_x == (SEL_W + 1)'(i));
      end
   end

endmodule

// File: rtl/microstep_control_decoder.sv
// Multi-step micro-op sequencer and control-word expander.
// Accepts an instruction (rs/rd) by valid/ready, walks a step counter that
// addresses the external microcode ROM and issues each expanded micro-op one
// cycle after it is sampled.
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid/ready        instruction handshake
//   instr_rs, instr_rd       source / destination register selects
//   step                     ROM address of the current micro-op
//   uop_word, uop_last       compressed micro-op and final-step marker
//   stall, abort, err_clr    sequencing controls
//   ctrl_out, ctrl_valid     expanded control word and its qualifier
//   instr_done               pulse alongside the last word of an instruction
//   busy                     sequencer is in RUN
//   err_overflow, err_badsel sticky error flags
//
// state | meaning
// IDLE  | waiting for an instruction, nothing issued
// RUN   | stepping through micro-ops, one expanded word per unstalled cycle
module microstep_control_decoder #(
   parameter int  CW_W      = 22,
   parameter int  NREG      = 4,
   parameter int  MAX_STEPS = 8,
   parameter int  LO_W      = mcd_pkg::LO_W,
   localparam int SEL_W     = (NREG > 1) ? $clog2(NREG) : 1,
   localparam int STEP_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1,
   localparam int OUT_W     = mcd_pkg::calc_out_w(CW_W, NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [SEL_W-1:0]  instr_rs,
   input  logic [SEL_W-1:0]  instr_rd,
   output logic [STEP_W-1:0] step,
   input  logic [CW_W-1:0]   uop_word,
   input  logic              uop_last,
   input  logic              stall,
   input  logic              abort,
   input  logic              err_clr,
   output logic [OUT_W-1:0]  ctrl_out,
   output logic              ctrl_valid,
   output logic              instr_done,
   output logic              busy,
   output logic              err_overflow,
   output logic              err_badsel
);

   import mcd_pkg::*;

   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

   state_e            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [SEL_W-1:0]  rs_q, rs_d, rd_q, rd_d;
   logic [OUT_W-1:0]  ctrl_out_q, ctrl_out_d;
   logic              ctrl_valid_q, ctrl_valid_d;
   logic              instr_done_q, instr_done_d;
   logic              err_overflow_q, err_overflow_d;
   logic              err_badsel_q, err_badsel_d;

   logic              ready_c, ovf_evt, bad_evt;
   logic [NREG-1:0]   in_en, out_en;
   logic              in_bad, out_bad;
   logic [OUT_W-1:0]  ctrl_word;

   onehot_reg_decoder #(.NREG(NREG)) u_in_dec (
      .sel    (rd_q),
      .en     (uop_word[LO_W + R_IN_OFS]),
      .onehot (in_en),
      .bad    (in_bad)
   );

   onehot_reg_decoder #(.NREG(NREG)) u_out_dec (
      .sel    (rs_q),
      .en     (uop_word[LO_W + R_OUT_OFS]),
      .onehot (out_en),
      .bad    (out_bad)
   );

   assign ctrl_word = {uop_word[CW_W-1:LO_W+2], out_en, in_en, uop_word[LO_W-1:0]};

   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      rs_d         = rs_q;
      rd_d         = rd_q;
      ctrl_out_d   = '0;
      ctrl_valid_d = 1'b0;
      instr_done_d = 1'b0;
      ready_c      = 1'b0;
      ovf_evt      = 1'b0;
      bad_evt      = 1'b0;

      if (abort) begin
         state_d = IDLE;
         step_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_c = 1'b1;
               if (instr_valid) begin
                  rs_d    = instr_rs;
                  rd_d    = instr_rd;
                  step_d  = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               // A stalled cycle issues a zero bubble so no enable repeats.
               if (!stall) begin
                  ctrl_out_d   = ctrl_word;
                  ctrl_valid_d = 1'b1;
                  bad_evt      = in_bad | out_bad;
                  if (uop_last) begin
                     instr_done_d = 1'b1;
                     ready_c      = 1'b1;
                     step_d       = '0;
                     if (instr_valid) begin
                        rs_d = instr_rs;
                        rd_d = instr_rd;
                     end else begin
                        state_d = IDLE;
                     end
                  end else if (step_q == STEP_LAST) begin
                     ovf_evt      = 1'b1;
                     instr_done_d = 1'b1;
                     step_d       = '0;
                     state_d      = IDLE;
                  end else begin
                     step_d = step_q + STEP_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               step_d  = '0;
            end
         endcase
      end

      // A new error in the clearing cycle keeps the flag set.
      err_overflow_d = ovf_evt | (err_overflow_q & ~err_clr);
      err_badsel_d   = bad_evt | (err_badsel_q & ~err_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         step_q         <= '0;
         rs_q           <= '0;
         rd_q           <= '0;
         ctrl_out_q     <= '0;
         ctrl_valid_q   <= 1'b0;
         instr_done_q   <= 1'b0;
         err_overflow_q <= 1'b0;
         err_badsel_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         step_q         <= step_d;
         rs_q           <= rs_d;
         rd_q           <= rd_d;
         ctrl_out_q     <= ctrl_out_d;
         ctrl_valid_q   <= ctrl_valid_d;
         instr_done_q   <= instr_done_d;
         err_overflow_q <= err_overflow_d;
         err_badsel_q   <= err_badsel_d;
      end
   end

   assign instr_ready  = ready_c;
   assign step         = step_q;
   assign ctrl_out     = ctrl_out_q;
   assign ctrl_valid   = ctrl_valid_q;
   assign instr_done   = instr_done_q;
   assign busy         = (state_q == RUN);
   assign err_overflow = err_overflow_q;
   assign err_badsel   = err_badsel_q;

endmodule
